// File: rtl/seg7_scan_mux.sv
// 4-digit multiplexed 7-segment driver with blanking gap and frame-synchronous value latch.
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module seg7_scan_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] BCD,
    input  logic        LOAD,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        FRAME_STB
);
    localparam int         CW      = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

    // cnt/dig point at the slot position the outputs will show after the next edge
    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   disp_val, pend_val, disp_nxt;
    logic          pending, commit, last_slot, blank, suppress;
    logic [3:0]    nib, an_on;
    logic [6:0]    seg_on;

    always_comb begin
        last_slot = (int'(cnt) == REFRESH_DIV - 1);
        blank     = (int'(cnt) < BLANK_CYC);
        commit    = FRAME_STB && pending;
        disp_nxt  = commit ? pend_val : disp_val;
        nib       = disp_nxt[{dig, 2'b00} +: 4];
        an_on     = 4'b0001 << dig;
`ifdef LEADING_ZERO_BLANK_EN
        suppress  = (dig != 2'd0) && ((disp_nxt >> {dig, 2'b00}) == 16'h0);
`else
        suppress  = 1'b0;
`endif
    end

    // active-high {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash
    always_comb begin
        seg_on = 7'b1000000;
        case (nib)
            4'd0: seg_on = 7'b0111111;
            4'd1: seg_on = 7'b0000110;
            4'd2: seg_on = 7'b1011011;
            4'd3: seg_on = 7'b1001111;
            4'd4: seg_on = 7'b1100110;
            4'd5: seg_on = 7'b1101101;
            4'd6: seg_on = 7'b1111101;
            4'd7: seg_on = 7'b0000111;
            4'd8: seg_on = 7'b1111111;
            4'd9: seg_on = 7'b1101111;
            default: seg_on = 7'b1000000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            dig       <= 2'd0;
            disp_val  <= 16'h0;
            pend_val  <= 16'h0;
            pending   <= 1'b0;
            SEG       <= SEG_OFF;
            AN        <= AN_OFF;
            DP        <= DP_OFF;
            FRAME_STB <= 1'b0;
        end else begin
            cnt      <= last_slot ? '0 : cnt + 1'b1;
            if (last_slot)
                dig <= dig + 2'd1;
            disp_val <= disp_nxt;
            // a LOAD on the commit edge re-arms pending with the new value
            if (LOAD) begin
                pend_val <= BCD;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end
            if (blank || suppress) begin
                AN  <= AN_OFF;
                SEG <= SEG_OFF;
            end else begin
                AN  <= (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
                SEG <= (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
            end
            DP        <= DP_OFF;
            FRAME_STB <= last_slot && (dig == 2'd3);
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (REFRESH_DIV=8, BLANK_CYC=2, active-low).
module tb_seg7_scan_mux;
    logic        CLK, RST, LOAD;
    logic [15:0] BCD;
    logic [6:0]  SEG;
    logic        DP, FRAME_STB;
    logic [3:0]  AN;

    int total = 0;
    int bad   = 0;
    int n;
    logic [15:0] m_disp, m_pend;
    logic        m_pending;
    logic [12:0] got, exp;

    seg7_scan_mux #(.REFRESH_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
        .CLK(CLK), .RST(RST), .BCD(BCD), .LOAD(LOAD),
        .SEG(SEG), .DP(DP), .AN(AN), .FRAME_STB(FRAME_STB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // expected {AN, SEG, DP, FRAME_STB} for cycle n showing value dv
    function automatic logic [12:0] exp_vec(input int cyc, input logic [15:0] dv);
        int c, d;
        logic [3:0] nb, a;
        logic [6:0] s;
        logic off;
        c   = cyc % 8;
        d   = (cyc / 8) % 4;
        nb  = dv[4*d +: 4];
        off = (c < 2);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (dv >> (4*d)) == 16'h0) off = 1'b1;
`endif
        case (nb)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        a = 4'hF;
        a[d] = 1'b0;
        if (off) begin
            a = 4'hF;
            s = 7'h7F;
        end
        return {a, s, 1'b1, ((cyc % 32) == 31)};
    endfunction

    // drive one cycle; model: frame-end commit happens before a coincident LOAD
    task automatic tick(input logic ld, input logic [15:0] v);
        LOAD = ld;
        BCD  = ld ? v : 16'($urandom);
        @(posedge CLK); #1;
        if ((n % 32) == 31 && m_pending) begin
            m_disp    = m_pend;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_pend    = v;
            m_pending = 1'b1;
        end
        n++;
        LOAD = 1'b0;
    endtask

    task automatic reset_dut();
        RST = 1'b1; LOAD = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        n = 0; m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; LOAD = 1'b1; BCD = 16'h5678;
        @(posedge CLK); #1;
        total++;
        if ({AN, SEG, DP, FRAME_STB} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", {AN, SEG, DP, FRAME_STB}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        LOAD = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;
        n = 0; m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
        repeat (40) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", n, got, exp); end
            tick(1'b0, 16'h0);
        end
    endtask

    task automatic test_idle();
        reset_dut();
        repeat (32) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL idle cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 2) begin
                total++;
                if ({AN, SEG} !== {4'b1110, 7'b1000000}) begin bad++; $display("FAIL idle_c2 got=%b exp=%b", {AN, SEG}, {4'b1110, 7'b1000000}); end
            end
            if (n == 31) begin
                total++;
                if (FRAME_STB !== 1'b1) begin bad++; $display("FAIL idle_stb got=%b exp=1", FRAME_STB); end
            end
            tick(1'b0, 16'h0);
        end
    endtask

    task automatic test_load();
        reset_dut();
        repeat (64) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL load cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 34 || n == 58) begin
                total++;
                if (SEG !== ((n == 34) ? 7'b0011001 : 7'b1111001)) begin bad++; $display("FAIL load_digit cyc=%0d got=%b", n, SEG); end
            end
            tick(n == 5, 16'h1234);
        end
    endtask

    task automatic test_last_wins();
        reset_dut();
        repeat (64) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL last_wins cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 42) begin
                total++;
                if (SEG !== 7'b0011001) begin bad++; $display("FAIL last_wins_tens got=%b exp=0011001", SEG); end
            end
            if (n == 3) tick(1'b1, 16'h1111);
            else tick(n == 20, 16'h0042);
        end
    endtask

    task automatic test_load_at_stb();
        reset_dut();
        repeat (72) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL load_at_stb cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 34 || n == 66) begin
                total++;
                if (SEG !== ((n == 34) ? 7'b1000000 : 7'b0010000)) begin bad++; $display("FAIL load_at_stb_ones cyc=%0d got=%b", n, SEG); end
            end
            tick(n == 31, 16'h0009);
        end
    endtask

    task automatic test_invalid();
        reset_dut();
        repeat (64) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL invalid cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 34 || n == 42) begin
                total++;
                if (SEG !== ((n == 34) ? 7'b0010010 : 7'b0111111)) begin bad++; $display("FAIL invalid_digit cyc=%0d got=%b", n, SEG); end
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (n == 50 || n == 60) begin
                total++;
                if (AN !== 4'hF) begin bad++; $display("FAIL lzb_an cyc=%0d got=%b exp=1111", n, AN); end
            end
`endif
            tick(n == 0, 16'h00A5);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        repeat (13) tick(n == 10, 16'h0042);
        RST = 1'b1;
        @(posedge CLK); #1;
        total++;
        if ({AN, SEG, DP, FRAME_STB} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", {AN, SEG, DP, FRAME_STB}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n = 0; m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
        repeat (64) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL mid_reset_after cyc=%0d got=%h exp=%h", n, got, exp); end
            if (n == 34) begin
                total++;
                if (SEG !== 7'b1000000) begin bad++; $display("FAIL mid_reset_nocommit got=%b exp=1000000", SEG); end
            end
            tick(1'b0, 16'h0);
        end
    endtask

    task automatic test_random();
        reset_dut();
        repeat (600) begin
            got = {AN, SEG, DP, FRAME_STB}; exp = exp_vec(n, m_disp); total++;
            if (got !== exp) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", n, got, exp); end
            tick($urandom_range(0, 9) == 0, 16'($urandom));
        end
    endtask

    initial begin
        RST = 1'b1; LOAD = 1'b0; BCD = 16'h0; n = 0;
        m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
        test_reset();
        test_idle();
        test_load();
        test_last_wins();
        test_load_at_stb();
        test_invalid();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Consumes the 16-bit packed BCD score value (4 digits) from the binary-to-BCD converter in the Pong score path.
- Drives a 4-digit common-anode multiplexed 7-segment display.
- Scans digits with a programmable refresh rate and an inter-digit blanking gap for ghost suppression.
- Latches new values only at frame boundaries so a displayed frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYC < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 = SEG/DP driven low to light a segment.
- AN_ACTIVE_LOW, 1: 1 = AN driven low to enable a digit.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- BCD  in  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
- LOAD  in  1  single-cycle strobe; capture BCD as the pending value
- SEG  out  7  segments {g,f,e,d,c,b,a}
- DP  out  1  decimal point; always unlit
- AN  out  4  digit enables; AN[k] selects digit k (0 = ones)
- FRAME_STB  out  1  one-cycle pulse on the last cycle of each 4-digit frame

Behaviour:
- State: slot counter cnt (0..REFRESH_DIV-1), digit index dig (0..3), disp_val[15:0], pend_val[15:0], pending flag. Phase is BLANK when cnt < BLANK_CYC, DRIVE otherwise.
- Reset (RST=1 at a CLK edge): cnt=0, dig=0, disp_val=0, pend_val=0, pending=0. All outputs registered and inactive: AN all off, SEG all off, DP off, FRAME_STB=0.
- Reset mid-scan aborts the frame immediately. Pending data is discarded.
- Counting: cnt increments each cycle. When cnt reaches REFRESH_DIV-1, it wraps to 0 and dig increments; dig wraps from 3 to 0.
- Output timing: n = index of the cycle after the first edge with RST=0, starting at 0.
  - Outputs in cycle n reflect cnt = n mod REFRESH_DIV and dig = (n div REFRESH_DIV) mod 4.
  - Outputs are registered with lookahead, so there is no extra latency.
- BLANK phase: AN all off, SEG all off.
- DRIVE phase:
  - AN: only AN[dig] active.
  - SEG = decode(disp_val[4*dig+3:4*dig]).
  - Decode 0-9: standard hex patterns.
  - Nibbles 10-15 are invalid and show segment g only ("-").
- FRAME_STB = 1 in the cycle where dig=3 and cnt=REFRESH_DIV-1.
- LOAD handling: LOAD=1 sets pend_val<=BCD and pending<=1.
  - Multiple LOADs within a frame: the last one wins.
  - BCD is sampled only on LOAD cycles.
- Commit: on the FRAME_STB cycle, if pending=1 (as registered before that edge), disp_val<=pend_val and pending<=0. The new value is displayed from the next cycle (dig=0, cnt=0).
- LOAD coincident with FRAME_STB:
  - Any earlier pending value commits.
  - The LOAD value goes to pend_val with pending=1 and commits at the next frame end.
  - With no earlier pending value, disp_val is unchanged.
- Polarity: SEG/DP are inverted when SEG_ACTIVE_LOW=1; AN is inverted when AN_ACTIVE_LOW=1. "Off" means the inactive level.
- BLANK_CYC=0: no blank phase; AN is active for the whole slot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) is suppressed when its nibble and all higher nibbles of disp_val are 0.
  - Suppression keeps AN and SEG off for the whole slot; slot timing is unchanged.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Invalid nibbles are never treated as zero.
- Undefined: all four digits are always driven, including leading zeros.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYC=2, active-low polarity.
- Reset, then run 32 cycles with no LOAD -> AN=1111 in cycles 0-1, AN=1110 with SEG=1000000 ("0") in cycles 2-7. Pattern repeats for AN=1101/1011/0111. FRAME_STB=1 only in cycle 31.
- LOAD with BCD=16'h1234 in cycle 5 -> digits keep showing 0 through cycle 31. From cycle 32: ones slot SEG=0011001 ("4"), then "3", "2", and thousands slot SEG=1111001 ("1").
- LOAD 16'h1111 in cycle 3, then LOAD 16'h0042 in cycle 20 -> frame starting at cycle 32 shows 0042; 1111 is never displayed.
- LOAD 16'h0009 exactly in cycle 31 (FRAME_STB) with nothing pending -> frame 32-63 still shows 0000; cycle 64 onward shows 0009.
- BCD=16'h00A5 loaded -> tens slot SEG=0111111 ("-"), ones slot SEG=0010010 ("5"). With LEADING_ZERO_BLANK_EN: hundreds and thousands slots have AN=1111 throughout, and the tens slot still shows "-".
- RST asserted in cycle 13 with 16'h0042 pending -> from the next cycle all outputs are inactive. After release, the display shows 0000 and pending stays clear (no commit at the next frame end).
